// File: rtl/pcie_rx_block_descrambler.sv
// pcie_rx_block_descrambler
//   128b/130b receive descrambler for one PCIe Gen3+ lane. Tracks 16-byte block boundaries,
//   classifies each block (data / SKP / EIEOS / other ordered set) and descrambles data-block
//   bytes with a 23-bit Galois LFSR advanced BYTES*8 bits per valid beat. All outputs are
//   registered, giving exactly one cycle of latency.
// Ports
//   i_clk, i_reset            PIPE RX clock, synchronous active-low reset
//   i_bypass                  1: data passes unmodified and the LFSR holds
//   i_seed                    per-lane seed, loaded at reset and after every EIEOS block
//   i_valid, i_block_start    beat qualifier, first beat of a 130b block
//   i_sync_header, i_data     2-bit sync header (sampled on block start), symbols (byte 0 first)
//   o_valid, o_block_start,
//   o_sync_header             registered copies of the inputs
//   o_data                    descrambled symbols
//   o_is_os                   current block is an ordered set
//   o_err_sync_header         pulse: illegal sync header on a block start
//   o_err_align               pulse: block start with beat counter != 0
module pcie_rx_block_descrambler #(
    parameter int unsigned BYTES  = 4,
    parameter int unsigned SEED_W = 23
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bypass,
    input  logic [SEED_W-1:0]    i_seed,
    input  logic                 i_valid,
    input  logic                 i_block_start,
    input  logic [1:0]           i_sync_header,
    input  logic [8*BYTES-1:0]   i_data,
    output logic                 o_valid,
    output logic                 o_block_start,
    output logic [1:0]           o_sync_header,
    output logic [8*BYTES-1:0]   o_data,
    output logic                 o_is_os,
    output logic                 o_err_sync_header,
    output logic                 o_err_align
);

    localparam int unsigned BEATS = 16 / BYTES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    // Feedback taps for x^23+x^21+x^16+x^8+x^5+x^2+1 (bits 21,16,8,5,2,0).
    localparam logic [SEED_W-1:0] TAPS = SEED_W'(23'h210125);

    typedef enum logic [2:0] {StIdle, StData, StSkp, StEieos, StOs} state_e;

    state_e               r_state, w_state_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic [SEED_W-1:0]    r_lfsr, w_lfsr_d;

    logic [SEED_W-1:0]    w_lfsr_adv;
    logic [8*BYTES-1:0]   w_mask;
    logic                 w_start, w_sh_bad, w_last, w_reload;
    state_e               w_class, w_cur;
    logic [CNT_W-1:0]     w_idx;

    logic [8*BYTES-1:0]   w_data_o;
    logic                 w_is_os_o, w_err_sh_o, w_err_al_o;

    // Unrolled LFSR walk: mask bit i is the scramble bit after i advances, LSB of byte 0 first.
    always_comb begin
        w_lfsr_adv = r_lfsr;
        w_mask     = '0;
        for (int i = 0; i < 8 * BYTES; i++) begin
            w_mask[i]  = w_lfsr_adv[SEED_W-1];
            w_lfsr_adv = {w_lfsr_adv[SEED_W-2:0], 1'b0} ^
                         (w_lfsr_adv[SEED_W-1] ? TAPS : '0);
        end
    end

    // Block classification from the block-start beat.
    always_comb begin
        w_start  = i_valid && i_block_start;
        w_sh_bad = (i_sync_header == 2'b00) || (i_sync_header == 2'b11);
        if (w_sh_bad)                   w_class = StIdle;
        else if (i_sync_header == 2'b10) w_class = StData;
        else if (i_data[7:0] == 8'hAA)  w_class = StSkp;
        else if (i_data[7:0] == 8'h00)  w_class = StEieos;
        else                            w_class = StOs;
        // The start beat already belongs to the new block.
        w_cur  = w_start ? w_class : r_state;
        w_idx  = w_start ? '0 : r_cnt;
        w_last = i_valid && (w_idx == LAST);
        // Normal EIEOS end, or an early start that lands on the EIEOS's last beat.
        w_reload = (w_last && (w_cur == StEieos)) ||
                   (w_start && (r_cnt == LAST) && (r_cnt != '0) && (r_state == StEieos));
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_lfsr_d  = r_lfsr;
        if (i_valid) begin
            // Block complete: wait in idle for the next start.
            if (w_last)       w_state_d = StIdle;
            else if (w_start) w_state_d = w_class;
            w_cnt_d = (w_idx == LAST) ? '0 : w_idx + CNT_W'(1);
            if (!i_bypass) begin
                if (w_reload)                                w_lfsr_d = i_seed;
                else if ((w_cur == StData) || (w_cur == StOs)) w_lfsr_d = w_lfsr_adv;
            end
        end
    end

    // Output logic (registered below).
    always_comb begin
        w_data_o = i_data;
        if (i_valid && !i_bypass && (w_cur == StData)) w_data_o = i_data ^ w_mask;
        w_is_os_o  = (w_cur == StSkp) || (w_cur == StEieos) || (w_cur == StOs);
        w_err_sh_o = w_start && w_sh_bad;
        w_err_al_o = w_start && (r_cnt != '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state           <= StIdle;
            r_cnt             <= '0;
            r_lfsr            <= i_seed;
            o_valid           <= 1'b0;
            o_block_start     <= 1'b0;
            o_sync_header     <= 2'b00;
            o_data            <= '0;
            o_is_os           <= 1'b0;
            o_err_sync_header <= 1'b0;
            o_err_align       <= 1'b0;
        end else begin
            r_state           <= w_state_d;
            r_cnt             <= w_cnt_d;
            r_lfsr            <= w_lfsr_d;
            o_valid           <= i_valid;
            o_block_start     <= i_block_start;
            o_sync_header     <= i_sync_header;
            o_data            <= w_data_o;
            o_is_os           <= w_is_os_o;
            o_err_sync_header <= w_err_sh_o;
            o_err_align       <= w_err_al_o;
        end
    end

endmodule

// File: tb/tb_pcie_rx_block_descrambler.sv
// tb_pcie_rx_block_descrambler
//   Directed bench for the 4-byte-per-beat descrambler. A bit-serial LFSR model produces the
//   expected descrambler masks; every comparison goes through check().
module tb_pcie_rx_block_descrambler;

    localparam logic [22:0] SEED = 23'h1DBFBC;
    localparam logic [22:0] POLY = 23'((1 << 21) | (1 << 16) | (1 << 8) | (1 << 5) | (1 << 2) | 1);

    logic        clk = 1'b0;
    logic        rst_n, bypass, valid, bstart;
    logic [1:0]  sh;
    logic [31:0] din;
    logic [22:0] seed;
    logic        o_valid, o_bstart, o_is_os, o_err_sh, o_err_al;
    logic [1:0]  o_sh;
    logic [31:0] o_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [22:0] m_lfsr;
    logic [31:0] m_mask;
    logic [31:0] first_blk [4];

    always #5 clk = ~clk;

    pcie_rx_block_descrambler #(.BYTES(4), .SEED_W(23)) dut (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_bypass          (bypass),
        .i_seed            (seed),
        .i_valid           (valid),
        .i_block_start     (bstart),
        .i_sync_header     (sh),
        .i_data            (din),
        .o_valid           (o_valid),
        .o_block_start     (o_bstart),
        .o_sync_header     (o_sh),
        .o_data            (o_data),
        .o_is_os           (o_is_os),
        .o_err_sync_header (o_err_sh),
        .o_err_align       (o_err_al)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Bit-serial reference: 32 shifts, scramble bit taken from bit 22 before each shift.
    task automatic mdl_next(output logic [31:0] m);
        logic fb;
        for (int i = 0; i < 32; i++) begin
            fb     = m_lfsr[22];
            m[i]   = fb;
            m_lfsr = m_lfsr << 1;
            if (fb) m_lfsr = m_lfsr ^ POLY;
        end
    endtask

    // Drive one beat, then sample the registered result 1 time unit after the edge.
    task automatic beat(input logic v, input logic s, input logic [1:0] h, input logic [31:0] d);
        valid  = v;
        bstart = s;
        sh     = h;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic data_block(input string tag, input logic [31:0] d, input logic save);
        for (int b = 0; b < 4; b++) begin
            beat(1'b1, b == 0, 2'b10, d);
            mdl_next(m_mask);
            if (save) first_blk[b] = m_mask;
            check(tag, o_data, d ^ m_mask);
        end
        check({tag, "_os"}, o_is_os, 0);
    endtask

    task automatic os_block(input string tag, input logic [31:0] d0, input logic adv);
        for (int b = 0; b < 4; b++) begin
            beat(1'b1, b == 0, 2'b01, (b == 0) ? d0 : 32'h5A5A_0000 + b);
            if (adv) mdl_next(m_mask);
            check(tag, o_data, (b == 0) ? d0 : 32'h5A5A_0000 + b);
            check({tag, "_os"}, o_is_os, 1);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bypass = 1'b0;
        seed   = SEED;
        // Reset dominates active inputs.
        beat(1'b1, 1'b1, 2'b10, 32'hDEADBEEF);
        beat(1'b1, 1'b0, 2'b11, 32'hDEADBEEF);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_sh", o_sh, 0);
        check("rst_bs", o_bstart, 0);
        check("rst_err", {o_is_os, o_err_sh, o_err_al}, 0);
        rst_n  = 1'b1;
        m_lfsr = SEED;

        // Bypass: data untouched, LFSR must not move.
        bypass = 1'b1;
        for (int b = 0; b < 4; b++) begin
            beat(1'b1, b == 0, 2'b10, 32'hDEADBEEF);
            check("byp_data", o_data, 32'hDEADBEEF);
            check("byp_valid", o_valid, 1);
        end
        bypass = 1'b0;

        // Idle invalid beat passes through, not valid.
        beat(1'b0, 1'b0, 2'b10, 32'h1234_5678);
        check("inv_valid", o_valid, 0);
        check("inv_data", o_data, 32'h1234_5678);

        data_block("data0", 32'h0, 1'b1);

        os_block("skp", 32'h0000_00AA, 1'b0);
        data_block("after_skp", 32'h0, 1'b0);

        os_block("os", 32'h0000_001E, 1'b1);
        data_block("after_os", 32'hA5C3_0F81, 1'b0);

        os_block("eieos", 32'hFFFF_FF00, 1'b0);
        m_lfsr = SEED;
        for (int b = 0; b < 4; b++) begin
            beat(1'b1, b == 0, 2'b10, 32'h0);
            mdl_next(m_mask);
            check("after_eieos", o_data, first_blk[b]);
        end

        // Early block start on beat 2 realigns.
        beat(1'b1, 1'b1, 2'b10, 32'h0);
        mdl_next(m_mask);
        check("al_d0", o_data, m_mask);
        beat(1'b1, 1'b0, 2'b10, 32'h0);
        mdl_next(m_mask);
        check("al_err_before", o_err_al, 0);
        beat(1'b1, 1'b1, 2'b10, 32'h0);
        mdl_next(m_mask);
        check("al_err", o_err_al, 1);
        check("al_d2", o_data, m_mask);
        for (int b = 1; b < 4; b++) begin
            beat(1'b1, 1'b0, 2'b10, 32'h0);
            mdl_next(m_mask);
            check("al_pulse", o_err_al, 0);
            check("al_dn", o_data, m_mask);
        end
        beat(1'b1, 1'b1, 2'b10, 32'h0);
        mdl_next(m_mask);
        check("al_next_start", o_err_al, 0);
        check("al_next_data", o_data, m_mask);
        for (int b = 1; b < 4; b++) begin
            beat(1'b1, 1'b0, 2'b10, 32'h0);
            mdl_next(m_mask);
            check("al_next_dn", o_data, m_mask);
        end

        // Illegal sync header.
        beat(1'b1, 1'b1, 2'b11, 32'hCAFE_0001);
        check("sh_err", o_err_sh, 1);
        check("sh_os", o_is_os, 0);
        check("sh_data", o_data, 32'hCAFE_0001);
        check("sh_osh", o_sh, 2'b11);
        beat(1'b1, 1'b0, 2'b10, 32'hCAFE_0002);
        check("sh_pulse", o_err_sh, 0);
        check("sh_idle_data", o_data, 32'hCAFE_0002);
        beat(1'b1, 1'b0, 2'b10, 32'h0);
        beat(1'b1, 1'b0, 2'b10, 32'h0);

        // Reset in the middle of a data block.
        beat(1'b1, 1'b1, 2'b10, 32'h0);
        mdl_next(m_mask);
        check("mid_data", o_data, m_mask);
        check("mid_bs", o_bstart, 1);
        rst_n = 1'b0;
        beat(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_flags", {o_bstart, o_sh, o_is_os, o_err_sh, o_err_al}, 0);
        rst_n  = 1'b1;
        m_lfsr = SEED;
        data_block("post_rst", 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
